// File: rtl/cpu_pkg.sv
// Shared encodings for the MEM stage: access widths,
// writeback source select and the MEM FSM states.
package cpu_pkg;

  localparam logic [1:0] MEM_W_BYTE = 2'd0;
  localparam logic [1:0] MEM_W_HALF = 2'd1;
  localparam logic [1:0] MEM_W_WORD = 2'd2;

  localparam logic [1:0] REG_SRC_ALU = 2'd0;
  localparam logic [1:0] REG_SRC_MEM = 2'd1;
  localparam logic [1:0] REG_SRC_PC  = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Store lane replication / byte enables and load extract with extension.
// st_*: store side from live inputs; ld_*: load side from latched fields.
module mem_lane_align
  import cpu_pkg::*;
(
  input  logic [1:0]  st_width_i,
  input  logic [1:0]  st_off_i,
  input  logic        st_we_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_be_o,
  input  logic [1:0]  ld_width_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_sign_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [15:0] sh;

  always_comb begin
    st_wdata_o = st_data_i;
    st_be_o    = 4'b1111;
    if (st_we_i) begin
      case (st_width_i)
        MEM_W_BYTE: begin
          st_wdata_o = {4{st_data_i[7:0]}};
          st_be_o    = 4'b0001 << st_off_i;
        end
        MEM_W_HALF: begin
          st_wdata_o = {2{st_data_i[15:0]}};
          st_be_o    = 4'b0011 << st_off_i;
        end
        default: begin
          st_wdata_o = st_data_i;
          st_be_o    = 4'b1111;
        end
      endcase
    end
  end

  assign sh = 16'(ld_rdata_i >> {ld_off_i, 3'b000});

  always_comb begin
    case (ld_width_i)
      MEM_W_BYTE:
        ld_data_o = {{24{ld_sign_i & sh[7]}}, sh[7:0]};
      MEM_W_HALF:
        ld_data_o = {{16{ld_sign_i & sh[15]}}, sh[15:0]};
      default:
        ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: load/store over a req/ready data-memory port, stalls upstream
// while busy, registers the MEM_WB writeback fields.
// In: EX_MEM fields, dmem_ready_i/rdata_i. Out: dmem_*, stall_o, wb_*, misalign_o, bus_err_o.
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] advance_pc_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] reg_2_data_i,
  input  logic [4:0]  reg_write_data_addr_i,
  input  logic [1:0]  mem_width_i,
  input  logic        mem_sign_extend_i,
  input  logic [1:0]  reg_src_i,
  input  logic        mem_write_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ready_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_addr_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int CW =
    (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIM_M1 =
    CW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

  mem_state_e state_q, state_d;

  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    width_q, width_d;
  logic          sign_q, sign_d;
  logic [1:0]    off_q, off_d;
  logic [4:0]    rd_q, rd_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [4:0]    wb_addr_q, wb_addr_d;
  logic          mis_q, mis_d;
  logic          berr_q, berr_d;

  logic          mem_op;
  logic          mis;
  logic          is_half;
  logic          is_word;
  logic          timeout;
  logic [1:0]    off;
  logic [31:0]   st_wdata;
  logic [3:0]    st_be;
  logic [31:0]   ld_data;

  assign off     = alu_result_i[1:0];
  assign mem_op  = mem_write_i
                 | (reg_src_i == REG_SRC_MEM);
  assign is_half = (mem_width_i == MEM_W_HALF);
  assign is_word = (mem_width_i == MEM_W_WORD)
                 | (mem_width_i == 2'd3);
  assign mis     = (is_half & off[0])
                 | (is_word & (off != 2'd0));
  assign timeout = (WAIT_LIMIT != 0)
                 && (wait_q == LIM_M1)
                 && !dmem_ready_i;

  mem_lane_align u_align (
    .st_width_i (mem_width_i),
    .st_off_i   (off),
    .st_we_i    (mem_write_i),
    .st_data_i  (reg_2_data_i),
    .st_wdata_o (st_wdata),
    .st_be_o    (st_be),
    .ld_width_i (width_q),
    .ld_off_i   (off_q),
    .ld_sign_i  (sign_q),
    .ld_rdata_i (dmem_rdata_i),
    .ld_data_o  (ld_data)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    width_d    = width_q;
    sign_d     = sign_q;
    off_d      = off_q;
    rd_d       = rd_q;
    wait_d     = wait_q;
    wb_data_d  = wb_data_q;
    wb_addr_d  = 5'd0;
    mis_d      = 1'b0;
    berr_d     = 1'b0;
    stall_o    = 1'b0;
    dmem_req_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!mem_op) begin
          wb_addr_d = reg_write_data_addr_i;
          wb_data_d = (reg_src_i == REG_SRC_PC)
                    ? advance_pc_i : alu_result_i;
        end else if (mis) begin
          mis_d = 1'b1;
        end else begin
          stall_o = 1'b1;
          we_d    = mem_write_i;
          addr_d  = {alu_result_i[31:2], 2'b00};
          be_d    = st_be;
          wdata_d = st_wdata;
          width_d = mem_width_i;
          sign_d  = mem_sign_extend_i;
          off_d   = off;
          rd_d    = reg_write_data_addr_i;
          wait_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        dmem_req_o = 1'b1;
        if (dmem_ready_i) begin
          state_d = IDLE;
          if (!we_q) begin
            wb_addr_d = rd_q;
            wb_data_d = ld_data;
          end
        end else if (timeout) begin
          // Let the faulting op leave EX_MEM.
          state_d = IDLE;
          berr_d  = 1'b1;
        end else begin
          stall_o = 1'b1;
          wait_d  = wait_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      width_q   <= '0;
      sign_q    <= 1'b0;
      off_q     <= '0;
      rd_q      <= '0;
      wait_q    <= '0;
      wb_data_q <= '0;
      wb_addr_q <= '0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      width_q   <= width_d;
      sign_q    <= sign_d;
      off_q     <= off_d;
      rd_q      <= rd_d;
      wait_q    <= wait_d;
      wb_data_q <= wb_data_d;
      wb_addr_q <= wb_addr_d;
      mis_q     <= mis_d;
      berr_q    <= berr_d;
    end
  end

  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign dmem_be_o    = be_q;
  assign wb_data_o    = wb_data_q;
  assign wb_addr_o    = wb_addr_q;
  assign misalign_o   = mis_q;
  assign bus_err_o    = berr_q;

endmodule
